exc_ctrl: RTL and testbench

Exception/interrupt controller that drives the CP0 register file and consumes its read port.
- Detects synchronous exceptions from the pipeline, maskable hardware interrupts and `eret`.
- Sequences the EPC/Cause/Status writes into CP0 over its two write ports, then issues a PC redirect and pipeline flush.
- Sits between the MEM stage / interrupt pins and the CP0 register file.

---
 rtl/exc_ctrl_if.sv | 32 +++
 rtl/exc_ctrl.sv | 135 +++++++++++++
 tb/tb_exc_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_if.sv
// Pipeline/CP0 signal bundle for the exception controller.
// The controller attaches through the master modport; the pipeline and CP0 side through slave.
interface exc_ctrl_if;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret_valid;
  logic [31:0] pc;
  logic        bd;
  logic [5:0]  hw_int;
  logic [4:0]  cp0_ra;
  logic [31:0] cp0_rd;
  logic [1:0]  cp0_we;
  logic [4:0]  cp0_wa_a;
  logic [31:0] cp0_wd_a;
  logic [4:0]  cp0_wa_b;
  logic [31:0] cp0_wd_b;
  logic        busy;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    input  exc_valid, exc_code, eret_valid, pc, bd, hw_int, cp0_rd,
    output cp0_ra, cp0_we, cp0_wa_a, cp0_wd_a, cp0_wa_b, cp0_wd_b,
           busy, redirect, redirect_pc
  );

  modport slave (
    output exc_valid, exc_code, eret_valid, pc, bd, hw_int, cp0_rd,
    input  cp0_ra, cp0_we, cp0_wa_a, cp0_wd_a, cp0_wa_b, cp0_wd_b,
           busy, redirect, redirect_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt/eret sequencer: writes EPC/Cause/Status into CP0, then redirects the PC.
// Hardware interrupts are only enabled when EXC_CTRL_INT_EN is defined.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic       clk,
  input  logic       reset,
  exc_ctrl_if.master bus
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  typedef enum logic [2:0] {
    IDLE, SAVE, SET_EXL, REDIRECT, ERET_RD, ERET_CLR, ERET_JUMP
  } state_e;

  state_e      state_q;
  logic [5:0]  int_q;
  logic [31:0] epc_q;
  logic [4:0]  ra_q;
  logic [1:0]  we_q;
  logic [4:0]  wa_a_q;
  logic [31:0] wd_a_q;
  logic [4:0]  wa_b_q;
  logic [31:0] wd_b_q;
  logic        rmw_set_q;
  logic        rmw_clr_q;
  logic        redirect_q;
  logic [31:0] redirect_pc_q;

  logic        int_pend_d;
  logic [31:0] epc_d;
  logic [4:0]  code_d;
  logic [31:0] cause_d;

`ifdef EXC_CTRL_INT_EN
  always_ff @(posedge clk) begin
    if (reset) int_q <= '0;
    else       int_q <= bus.hw_int;
  end
`else
  logic unused_hw_int;
  assign int_q         = '0;
  assign unused_hw_int = ^bus.hw_int;
`endif

  // cp0_rd carries Status whenever the FSM sits in IDLE.
  assign int_pend_d = (|(int_q & bus.cp0_rd[15:10])) & bus.cp0_rd[0] & ~bus.cp0_rd[1];
  assign epc_d      = bus.bd ? (bus.pc - 32'd4) : bus.pc;
  assign code_d     = bus.exc_valid ? bus.exc_code : 5'd0;
  assign cause_d    = {bus.bd, 15'b0, int_q, 3'b0, code_d, 2'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      epc_q         <= '0;
      ra_q          <= REG_STATUS;
      we_q          <= '0;
      wa_a_q        <= '0;
      wd_a_q        <= '0;
      wa_b_q        <= '0;
      wd_b_q        <= '0;
      rmw_set_q     <= 1'b0;
      rmw_clr_q     <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      ra_q          <= REG_STATUS;
      we_q          <= '0;
      wa_a_q        <= '0;
      wd_a_q        <= '0;
      wa_b_q        <= '0;
      wd_b_q        <= '0;
      rmw_set_q     <= 1'b0;
      rmw_clr_q     <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.exc_valid || int_pend_d) begin
            epc_q   <= epc_d;
            we_q    <= 2'b11;
            wa_a_q  <= REG_EPC;
            wd_a_q  <= epc_d;
            wa_b_q  <= REG_CAUSE;
            wd_b_q  <= cause_d;
            state_q <= SAVE;
          end else if (bus.eret_valid) begin
            ra_q    <= REG_EPC;
            state_q <= ERET_RD;
          end
        end
        SAVE: begin
          we_q      <= 2'b10;
          wa_a_q    <= REG_STATUS;
          rmw_set_q <= 1'b1;
          state_q   <= SET_EXL;
        end
        SET_EXL: begin
          redirect_q    <= 1'b1;
          redirect_pc_q <= HANDLER_ADDR;
          state_q       <= REDIRECT;
        end
        ERET_RD: begin
          epc_q     <= bus.cp0_rd;
          we_q      <= 2'b10;
          wa_a_q    <= REG_STATUS;
          rmw_clr_q <= 1'b1;
          state_q   <= ERET_CLR;
        end
        ERET_CLR: begin
          redirect_q    <= 1'b1;
          redirect_pc_q <= epc_q;
          state_q       <= ERET_JUMP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status read-modify-write uses the value read in the same cycle as the write.
  assign bus.cp0_wd_a    = rmw_set_q ? (bus.cp0_rd | 32'h2) :
                           rmw_clr_q ? (bus.cp0_rd & ~32'h2) : wd_a_q;
  assign bus.cp0_we      = reset ? 2'b00 : we_q;
  assign bus.cp0_ra      = ra_q;
  assign bus.cp0_wa_a    = wa_a_q;
  assign bus.cp0_wa_b    = wa_b_q;
  assign bus.cp0_wd_b    = wd_b_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: CP0 register file model, transaction-level reference, directed + random stimulus.
module tb_exc_ctrl;

`ifdef EXC_CTRL_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        busy;
    logic [1:0]  we;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic [4:0]  wa_b;
    logic [31:0] wd_b;
    logic        redirect;
    logic [31:0] rpc;
    logic [4:0]  ra;
    logic        ra_chk;
  } exp_t;

  logic        clk;
  logic        reset;
  exc_ctrl_if  bus();
  logic [31:0] cp0 [32];

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        cur;
  exp_t        exp_q[$];
  logic [5:0]  int_m;
  bit          armed;
  logic [31:0] last_rpc;
  int          redir_cnt;

  logic        in_rst, in_exc, in_eret, in_bd;
  logic [4:0]  in_code;
  logic [31:0] in_pc;
  logic [5:0]  in_hw;

  exc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  assign bus.cp0_rd = cp0[bus.cp0_ra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e        = '0;
    e.ra     = 5'd12;
    e.ra_chk = 1'b1;
    return e;
  endfunction

  // One clock: drive inputs, check this cycle, predict the following ones, commit CP0 writes.
  task automatic tick();
    exp_t        nxt, e;
    logic [31:0] st, epc, cause;
    logic [4:0]  code;
    logic        pend;
    logic [5:0]  int_nxt;
    logic [1:0]  wr_we;
    logic [4:0]  wr_wa_a, wr_wa_b;
    logic [31:0] wr_wd_a, wr_wd_b;
    @(negedge clk);
    reset          = in_rst;
    bus.exc_valid  = in_exc;
    bus.exc_code   = in_code;
    bus.eret_valid = in_eret;
    bus.pc         = in_pc;
    bus.bd         = in_bd;
    bus.hw_int     = in_hw;
    #1;
    if (armed) begin
      check_eq("busy", bus.busy, cur.busy);
      check_eq("cp0_we", bus.cp0_we, in_rst ? 2'b00 : cur.we);
      check_eq("redirect", bus.redirect, cur.redirect);
      check_eq("redirect_pc", bus.redirect_pc, cur.rpc);
      if (cur.ra_chk) check_eq("cp0_ra", bus.cp0_ra, cur.ra);
      if (cur.we[1] && !in_rst) begin
        check_eq("wa_a", bus.cp0_wa_a, cur.wa_a);
        check_eq("wd_a", bus.cp0_wd_a, cur.wd_a);
      end
      if (cur.we[0] && !in_rst) begin
        check_eq("wa_b", bus.cp0_wa_b, cur.wa_b);
        check_eq("wd_b", bus.cp0_wd_b, cur.wd_b);
      end
    end
    if (bus.redirect === 1'b1) begin
      last_rpc = bus.redirect_pc;
      redir_cnt++;
    end
    wr_we   = bus.cp0_we;
    wr_wa_a = bus.cp0_wa_a;
    wr_wd_a = bus.cp0_wd_a;
    wr_wa_b = bus.cp0_wa_b;
    wr_wd_b = bus.cp0_wd_b;

    st = cp0[12];
    if (in_rst) begin
      exp_q.delete();
      nxt     = idle_e();
      int_nxt = '0;
    end else begin
      if (!cur.busy) begin
        pend = INT_EN && ((int_m & st[15:10]) != 6'd0) && st[0] && !st[1];
        if (in_exc || pend) begin
          code  = in_exc ? in_code : 5'd0;
          epc   = in_bd ? in_pc - 32'd4 : in_pc;
          cause = (32'(in_bd) << 31) + (32'(int_m) << 10) + (32'(code) << 2);
          e = idle_e(); e.busy = 1; e.ra_chk = 0;
          e.we = 2'b11; e.wa_a = 5'd14; e.wd_a = epc; e.wa_b = 5'd13; e.wd_b = cause;
          exp_q.push_back(e);
          e = idle_e(); e.busy = 1; e.we = 2'b10; e.wa_a = 5'd12; e.wd_a = st | 32'h2;
          exp_q.push_back(e);
          e = idle_e(); e.busy = 1; e.ra_chk = 0; e.redirect = 1; e.rpc = 32'h0000_4180;
          exp_q.push_back(e);
        end else if (in_eret) begin
          e = idle_e(); e.busy = 1; e.ra = 5'd14;
          exp_q.push_back(e);
          e = idle_e(); e.busy = 1; e.we = 2'b10; e.wa_a = 5'd12; e.wd_a = st & ~32'h2;
          exp_q.push_back(e);
          e = idle_e(); e.busy = 1; e.ra_chk = 0; e.redirect = 1; e.rpc = cp0[14];
          exp_q.push_back(e);
        end
      end
      nxt     = (exp_q.size() != 0) ? exp_q.pop_front() : idle_e();
      int_nxt = INT_EN ? in_hw : 6'd0;
    end
    @(posedge clk);
    if (wr_we[1] === 1'b1) cp0[wr_wa_a] = wr_wd_a;
    if (wr_we[0] === 1'b1) cp0[wr_wa_b] = wr_wd_b;
    cur   = nxt;
    int_m = int_nxt;
    armed = 1'b1;
  endtask

  task automatic quiet_ticks(input int n);
    in_exc  = 1'b0;
    in_eret = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) cp0[i] = '0;
    cur = idle_e(); int_m = '0; armed = 1'b0; last_rpc = '0; redir_cnt = 0;
    in_rst = 1'b1; in_exc = 1'b0; in_eret = 1'b0; in_bd = 1'b0;
    in_code = '0; in_pc = '0; in_hw = '0;
    tick(); tick();
    in_rst = 1'b0;
    tick();

    // overflow exception
    cp0[12] = 32'h0;
    in_exc = 1'b1; in_code = 5'd12; in_pc = 32'h3000; in_bd = 1'b0;
    tick();
    quiet_ticks(4);
    check_eq("ovf_epc", cp0[14], 32'h0000_3000);
    check_eq("ovf_cause", cp0[13], 32'h0000_0030);
    check_eq("ovf_status", cp0[12], 32'h0000_0002);
    check_eq("ovf_rpc", last_rpc, 32'h0000_4180);

    // delay slot, then pc wrap
    cp0[12] = 32'h0;
    in_exc = 1'b1; in_code = 5'd12; in_pc = 32'h3008; in_bd = 1'b1;
    tick();
    quiet_ticks(4);
    check_eq("bd_epc", cp0[14], 32'h0000_3004);
    check_eq("bd_cause", cp0[13], 32'h8000_0030);
    cp0[12] = 32'h0;
    in_exc = 1'b1; in_pc = 32'h0; in_bd = 1'b1;
    tick();
    quiet_ticks(4);
    check_eq("wrap_epc", cp0[14], 32'hFFFF_FFFC);

    // interrupt entry (no entry without interrupt support)
    cp0[12] = 32'h401; cp0[13] = 32'h0; in_bd = 1'b0; in_pc = 32'h5000;
    in_hw = 6'b000001;
    quiet_ticks(6);
    check_eq("int_cause", cp0[13], INT_EN ? 32'h0000_0400 : 32'h0);
    check_eq("int_status", cp0[12], INT_EN ? 32'h0000_0403 : 32'h0000_0401);
    cp0[12] = 32'h403; cp0[13] = 32'h0;
    quiet_ticks(4);
    check_eq("int_exl_cause", cp0[13], 32'h0);
    in_hw = 6'b0;

    // eret
    cp0[14] = 32'h3004; cp0[12] = 32'h403; last_rpc = '0;
    in_eret = 1'b1;
    tick();
    quiet_ticks(4);
    check_eq("eret_status", cp0[12], 32'h0000_0401);
    check_eq("eret_rpc", last_rpc, 32'h0000_3004);

    // simultaneous exception, interrupt and eret
    cp0[12] = 32'h401; in_hw = 6'b000001;
    quiet_ticks(1);
    in_exc = 1'b1; in_code = 5'd5; in_eret = 1'b1; in_pc = 32'h6000;
    tick();
    quiet_ticks(4);
    check_eq("simul_cause", cp0[13], INT_EN ? 32'h0000_0414 : 32'h0000_0014);
    check_eq("simul_rpc", last_rpc, 32'h0000_4180);
    in_hw = 6'b0;

    // reset while in SET_EXL
    cp0[12] = 32'h0; redir_cnt = 0;
    in_exc = 1'b1; in_code = 5'd4; in_pc = 32'h7000;
    tick();
    quiet_ticks(1);
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    quiet_ticks(4);
    check_eq("rst_status", cp0[12], 32'h0);
    check_eq("rst_redirects", 32'(redir_cnt), 32'h0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if (!cur.busy && ($urandom_range(0, 2) == 0))
        cp0[12] = ($urandom & 32'hFFFF_03FC) | (32'($urandom_range(0, 63)) << 10) |
                  (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0) |
                  (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
      if (!cur.busy && ($urandom_range(0, 3) == 0)) cp0[14] = $urandom;
      in_rst  = ($urandom_range(0, 199) == 0);
      in_exc  = ($urandom_range(0, 4) == 0);
      in_eret = ($urandom_range(0, 3) == 0);
      in_code = 5'($urandom);
      in_pc   = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      in_bd   = 1'($urandom);
      in_hw   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      tick();
    end
    in_rst = 1'b0;
    quiet_ticks(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
